// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART controller pair: FSM state encoding and the
// ASCII framing characters that separate matrix bytes on the wire.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EXP_DATA = 3'd1,
      EXP_SP   = 3'd2,
      EXP_CR   = 3'd3,
      EXP_LF   = 3'd4,
      RESYNC   = 3'd5
   } state_t;

   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_rx_parser.sv
// Parses an N x N byte matrix received as text rows (D SP D ... CR LF) into a matrix buffer.
// Define UART_RX_ROW_CHECK_EN to compare separators and re-receive a row after a mismatch.
module uart_rx_parser
   import uart_ctrl_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int MAX_N = 255
) (
   input  logic             system_clock,
   input  logic             rst,
   input  logic             clock_enable,
   input  logic             start,
   input  logic [14:0]      num_bytes,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             rx_error,
   output logic             wr_en,
   output logic [CNT_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] data_counter,
   output logic             format_error,
   output state_t           dbg_state_o
);

`ifdef UART_RX_ROW_CHECK_EN
   localparam bit ROW_CHECK = 1'b1;
`else
   localparam bit ROW_CHECK = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [14:0]      n_q, n_d;
   logic [14:0]      col_q, col_d;
   logic [CNT_W-1:0] row_base_q, row_base_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_en_q, wr_en_d;
   logic [CNT_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ferr_q, ferr_d;
   logic             sep_bad;
   logic             n_ok;
   logic [29:0]      total;
   logic [29:0]      cnt_ext;

   assign total   = 30'(n_q) * 30'(n_q);
   assign cnt_ext = 30'(cnt_q);
   assign n_ok    = (num_bytes != 15'd0) && ({17'd0, num_bytes} <= 32'(MAX_N));

   // Without row checking every separator slot accepts any byte (position only).
   function automatic logic sep_match(input logic [7:0] b, input logic [7:0] exp_b);
      return !ROW_CHECK || (b == exp_b);
   endfunction

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      col_d      = col_q;
      row_base_d = row_base_q;
      cnt_d      = cnt_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ferr_d     = ferr_q;
      sep_bad    = 1'b0;

      // wr_en/done are single-clock strobes even when clock_enable is sparse.
      if (clock_enable) begin
         if ((state_q != IDLE) && rx_valid && rx_error) begin
            ferr_d = 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (start && n_ok) begin
                  n_d        = num_bytes;
                  col_d      = '0;
                  row_base_d = '0;
                  cnt_d      = '0;
                  ferr_d     = 1'b0;
                  busy_d     = 1'b1;
                  state_d    = EXP_DATA;
               end
            end
            EXP_DATA: begin
               if (rx_valid) begin
                  if (rx_error) begin
                     sep_bad = 1'b1;
                  end else begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = cnt_q;
                     wr_data_d = rx_data;
                     cnt_d     = cnt_q + CNT_W'(1);
                     if (col_q == n_q - 15'd1) begin
                        col_d   = '0;
                        state_d = EXP_CR;
                     end else begin
                        col_d   = col_q + 15'd1;
                        state_d = EXP_SP;
                     end
                  end
               end
            end
            EXP_SP: begin
               if (rx_valid) begin
                  if (!rx_error && sep_match(rx_data, ASCII_SP)) state_d = EXP_DATA;
                  else                                           sep_bad = 1'b1;
               end
            end
            EXP_CR: begin
               if (rx_valid) begin
                  if (!rx_error && sep_match(rx_data, ASCII_CR)) state_d = EXP_LF;
                  else                                           sep_bad = 1'b1;
               end
            end
            EXP_LF: begin
               if (rx_valid) begin
                  if (!rx_error && sep_match(rx_data, ASCII_LF)) begin
                     if (cnt_ext == total) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                     end else begin
                        row_base_d = cnt_q;
                        state_d    = EXP_DATA;
                     end
                  end else begin
                     sep_bad = 1'b1;
                  end
               end
            end
            RESYNC: begin
               if (rx_valid && !rx_error && (rx_data == ASCII_LF)) begin
                  col_d   = '0;
                  state_d = EXP_DATA;
               end
            end
            default: state_d = IDLE;
         endcase

         // A broken row is discarded whole; the sender repeats it after the next LF.
         if (sep_bad && ROW_CHECK) begin
            cnt_d   = row_base_q;
            col_d   = '0;
            state_d = RESYNC;
         end
      end
   end

   always_ff @(posedge system_clock) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         col_q      <= '0;
         row_base_q <= '0;
         cnt_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         col_q      <= col_d;
         row_base_q <= row_base_d;
         cnt_q      <= cnt_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign data_counter = cnt_q;
   assign format_error = ferr_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_rx_parser.sv
// Bench for uart_rx_parser: table of well-formed frames plus hand sequences for
// start/reset/error corner cases; buffer writes are checked against an expected queue.
module tb_uart_rx_parser;
   import uart_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        clock_enable;
   logic        start;
   logic [14:0] num_bytes;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_error;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy;
   logic        done;
   logic [15:0] data_counter;
   logic        format_error;
   state_t      dbg_state;

   int checks      = 0;
   int errors      = 0;
   int done_seen   = 0;
   int writes_seen = 0;
   int ce_div      = 1;

   logic [23:0] exp_q[$];

   typedef struct packed {
      logic [14:0]     n;
      logic [0:8][7:0] data;
      logic [15:0]     exp_cnt;
   } vec_t;

   localparam logic [0:8][7:0] F_ABCD = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 40'h0};
   localparam logic [0:8][7:0] F_55   = {8'h55, 64'h0};

   vec_t vecs[4];

   uart_rx_parser #(.CNT_W(16), .MAX_N(255)) dut (
      .system_clock (clk),
      .rst          (rst),
      .clock_enable (clock_enable),
      .start        (start),
      .num_bytes    (num_bytes),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_error     (rx_error),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .done         (done),
      .data_counter (data_counter),
      .format_error (format_error),
      .dbg_state_o  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard: every wr_en cycle must match the head of exp_q
   always @(negedge clk) begin
      if (wr_en) begin
         logic [23:0] e;
         checks++;
         writes_seen++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_wr: got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               errors++;
               $display("FAIL wr: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                        wr_addr, wr_data, e[23:8], e[7:0]);
            end
         end
      end
      if (done) done_seen++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // driver: one clock_enable slot, preceded by ce_div-1 disabled clocks
   task automatic step(input logic s, input logic [14:0] n, input logic v,
                       input logic [7:0] d, input logic e);
      for (int k = 1; k < ce_div; k++) begin
         clock_enable = 1'b0;
         start        = 1'b0;
         rx_valid     = 1'b0;
         rx_error     = 1'b0;
         @(posedge clk); #1;
      end
      clock_enable = 1'b1;
      start        = s;
      num_bytes    = n;
      rx_valid     = v;
      rx_data      = d;
      rx_error     = e;
      @(posedge clk); #1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b0, num_bytes, 1'b1, d, 1'b0);
   endtask

   task automatic send_err(input logic [7:0] d);
      step(1'b0, num_bytes, 1'b1, d, 1'b1);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b0, num_bytes, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic push(input int a, input logic [7:0] d);
      exp_q.push_back({16'(a), d});
   endtask

   task automatic begin_frame(input logic [14:0] n);
      done_seen = 0;
      step(1'b1, n, 1'b0, 8'h00, 1'b0);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("cnt_after_start", 32'(data_counter), 32'd0);
   endtask

   // complete well-formed frame; expected writes pushed as bytes are driven
   task automatic send_frame(input logic [14:0] n, input logic [0:8][7:0] d);
      int idx = 0;
      for (int r = 0; r < int'(n); r++) begin
         for (int c = 0; c < int'(n); c++) begin
            push(idx, d[idx]);
            send(d[idx]);
            idx++;
            if (c < int'(n) - 1) begin
               send(ASCII_SP);
            end else begin
               send(ASCII_CR);
               send(ASCII_LF);
            end
         end
      end
   endtask

   task automatic finish_frame(input logic [15:0] exp_cnt, input logic exp_ferr);
      chk("done_after_lf", 32'(done), 32'd1);
      idle(3);
      chk("done_pulses", 32'(done_seen), 32'd1);
      chk("data_counter", 32'(data_counter), 32'(exp_cnt));
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("format_error", 32'(format_error), 32'(exp_ferr));
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_values();
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_data_counter", 32'(data_counter), 32'd0);
      chk("rst_format_error", 32'(format_error), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
   endtask

   initial begin
      vec_t rv;
      int   w;

      vecs[0] = '{n: 15'd2, data: F_ABCD, exp_cnt: 16'd4};
      vecs[1] = '{n: 15'd1, data: F_55, exp_cnt: 16'd1};
      vecs[2] = '{n: 15'd3, data: {8'h00, 8'hFF, 8'h20, 8'h0D, 8'h0A, 8'h7E, 8'h80, 8'h01, 8'h5A},
                  exp_cnt: 16'd9};
      vecs[3] = '{n: 15'd2, data: {8'h0A, 8'h0D, 8'h20, 8'hFF, 40'h0}, exp_cnt: 16'd4};

      rst          = 1'b1;
      clock_enable = 1'b1;
      start        = 1'b0;
      num_bytes    = '0;
      rx_valid     = 1'b0;
      rx_data      = '0;
      rx_error     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_values();

      // rejected starts: N=0 and N>MAX_N
      step(1'b1, 15'd0, 1'b0, 8'h00, 1'b0);
      chk("start_n0_ignored", 32'(busy), 32'd0);
      step(1'b1, 15'd256, 1'b0, 8'h00, 1'b0);
      chk("start_n256_ignored", 32'(busy), 32'd0);
      step(1'b1, 15'd255, 1'b0, 8'h00, 1'b0);
      chk("start_n255_accepted", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // table of well-formed frames
      foreach (vecs[i]) begin
         begin_frame(vecs[i].n);
         send_frame(vecs[i].n, vecs[i].data);
         finish_frame(vecs[i].exp_cnt, 1'b0);
      end

      // bytes with no accepted start produce no writes
      w = writes_seen;
      send(8'h55);
      send(ASCII_CR);
      send(ASCII_LF);
      idle(2);
      chk("no_start_no_wr", 32'(writes_seen), 32'(w));
      chk("no_start_idle", 32'(busy), 32'd0);

      // 1-of-4 clock enable gives the same writes and done
      ce_div = 4;
      begin_frame(vecs[0].n);
      send_frame(vecs[0].n, vecs[0].data);
      finish_frame(vecs[0].exp_cnt, 1'b0);
      ce_div = 1;

      // start pulsed mid-frame is ignored
      begin_frame(15'd2);
      push(0, 8'hA1); send(8'hA1);
      send(ASCII_SP);
      step(1'b1, 15'd1, 1'b0, 8'h00, 1'b0);
      chk("mid_start_busy", 32'(busy), 32'd1);
      chk("mid_start_state", 32'(dbg_state), 32'(EXP_DATA));
      push(1, 8'hB2); send(8'hB2);
      send(ASCII_CR); send(ASCII_LF);
      push(2, 8'hC3); send(8'hC3);
      send(ASCII_SP);
      push(3, 8'hD4); send(8'hD4);
      send(ASCII_CR); send(ASCII_LF);
      finish_frame(16'd4, 1'b0);

      // reset after three bytes, then a clean frame
      done_seen = 0;
      begin_frame(15'd2);
      push(0, 8'hA1); send(8'hA1);
      send(ASCII_SP);
      push(1, 8'hB2); send(8'hB2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_values();
      idle(2);
      chk("rst_no_done", 32'(done_seen), 32'd0);
      begin_frame(15'd2);
      send_frame(15'd2, F_ABCD);
      finish_frame(16'd4, 1'b0);

      // rx_error on the second data byte
      begin_frame(15'd2);
      push(0, 8'hA1); send(8'hA1);
      send(ASCII_SP);
      send_err(8'hB2);
      chk("rx_err_ferr", 32'(format_error), 32'd1);
`ifdef UART_RX_ROW_CHECK_EN
      chk("rx_err_rewind", 32'(data_counter), 32'd0);
      chk("rx_err_resync", 32'(dbg_state), 32'(RESYNC));
      send(ASCII_CR);
      send(ASCII_LF);
      send_frame(15'd2, F_ABCD);
`else
      chk("rx_err_cnt", 32'(data_counter), 32'd1);
      push(1, 8'hB2); send(8'hB2);
      send(ASCII_CR); send(ASCII_LF);
      push(2, 8'hC3); send(8'hC3);
      send(ASCII_SP);
      push(3, 8'hD4); send(8'hD4);
      send(ASCII_CR); send(ASCII_LF);
`endif
      finish_frame(16'd4, 1'b1);
      begin_frame(15'd1);
      chk("ferr_cleared_by_start", 32'(format_error), 32'd0);
      send_frame(15'd1, F_55);
      finish_frame(16'd1, 1'b0);

      // wrong separator value (2C instead of 20)
      begin_frame(15'd2);
      push(0, 8'hA1); send(8'hA1);
      send(8'h2C);
`ifdef UART_RX_ROW_CHECK_EN
      chk("sep_ferr", 32'(format_error), 32'd1);
      chk("sep_resync", 32'(dbg_state), 32'(RESYNC));
      send(8'hB2);
      send(ASCII_CR);
      send(ASCII_LF);
      send_frame(15'd2, F_ABCD);
      finish_frame(16'd4, 1'b1);
`else
      chk("sep_ignored_state", 32'(dbg_state), 32'(EXP_DATA));
      push(1, 8'hB2); send(8'hB2);
      send(ASCII_CR); send(ASCII_LF);
      push(2, 8'hC3); send(8'hC3);
      send(ASCII_SP);
      push(3, 8'hD4); send(8'hD4);
      send(ASCII_CR); send(ASCII_LF);
      finish_frame(16'd4, 1'b0);
`endif

      // random frames
      for (int t = 0; t < 4; t++) begin
         rv.n = 15'($urandom_range(1, 3));
         for (int i = 0; i < 9; i++) rv.data[i] = 8'($urandom_range(0, 255));
         rv.exp_cnt = 16'(rv.n * rv.n);
         begin_frame(rv.n);
         send_frame(rv.n, rv.data);
         finish_frame(rv.exp_cnt, 1'b0);
      end

      idle(2);
      chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
